// File: rtl/mcc_mem_responder.sv
// -----------------------------------------------------------------------------
// mcc_mem_responder
//   Memory-side responder for the multi-cycle CPU's mem_* bus. It provides a
//   byte-lane RAM plus a small MMIO block. The MMIO block holds a free-running
//   cycle counter and a byte TX FIFO that a valid/ready sink drains.
//
//   Read data is combinational because the CPU latches mem_rdata in the same
//   cycle that it drives mem_addr. Every write commits on the rising clk edge.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous reset, active-high
//   mem_addr     byte address from the CPU
//                bit 31 = 0 selects RAM, bit 31 = 1 selects MMIO
//   mem_wdata    write data; byte k on bits [8k+7:8k]
//   mem_wenable  per-lane write enable; 4'b0000 = read/idle
//   mem_rdata    combinational read data for mem_addr
//   tx_data      FIFO head byte
//   tx_valid     FIFO non-empty
//   tx_ready     sink accepts the head when tx_valid && tx_ready
//
// MMIO map (decoded on mem_addr[3:2])
//   0 CYCLE      r/w  32-bit counter
//   1 TX_DATA    w    push byte (lane 0); reads 0
//   2 TX_STATUS  r/w  {16'b0, count[7:0], 5'b0, overflow, full, empty};
//                     writing bit 2 with lane 0 clears overflow
//   3 reserved        reads 0, writes ignored
// -----------------------------------------------------------------------------
module mcc_mem_responder #(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wenable,
   output logic [31:0] mem_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;   // count must hold FIFO_DEPTH itself

   typedef enum logic [1:0] {
      REG_CYCLE     = 2'd0,
      REG_TX_DATA   = 2'd1,
      REG_TX_STATUS = 2'd2,
      REG_RESERVED  = 2'd3
   } mmio_reg_e;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic            sel_ram;
   logic            sel_mmio;
   mmio_reg_e       mmio_reg;
   logic [AW-1:0]   ram_index;

   assign sel_ram   = ~mem_addr[31];
   assign sel_mmio  = mem_addr[31];
   assign mmio_reg  = mmio_reg_e'(mem_addr[3:2]);
   // Upper RAM address bits are ignored, so the RAM aliases across its window.
   assign ram_index = mem_addr[AW+1:2];

   // Only some address and data bits take part in the decode. This reduction
   // exists solely to tie off the remaining bits.
   logic unused_bits;
   assign unused_bits = ^{mem_addr, mem_wdata};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]   ram [RAM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          overflow;
   logic [31:0]   cycle_count;

   // ---------------------------------------------------------------------------
   // Write / push / pop qualification
   // ---------------------------------------------------------------------------
   logic ram_wr;
   logic cycle_wr;
   logic push_req;
   logic push_ok;
   logic pop;
   logic drop;
   logic ovf_clear;
   logic full;
   logic empty;

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign tx_valid  = ~empty;
   assign tx_data   = fifo_mem[head];

   assign ram_wr    = sel_ram & (|mem_wenable);
   assign cycle_wr  = sel_mmio & (mmio_reg == REG_CYCLE) & (|mem_wenable);
   assign push_req  = sel_mmio & (mmio_reg == REG_TX_DATA) & mem_wenable[0];
   assign ovf_clear = sel_mmio & (mmio_reg == REG_TX_STATUS) & mem_wenable[0]
                      & mem_wdata[2];

   assign pop       = tx_valid & tx_ready;
   // A pop on the same edge frees the slot. This holds even when the FIFO is
   // full. An empty FIFO has no pop, so no byte passes straight through.
   assign push_ok   = push_req & (~full | pop);
   assign drop      = push_req & full & ~pop;

   // ---------------------------------------------------------------------------
   // RAM: per-lane write and no reset
   // ---------------------------------------------------------------------------
   // NOTE: storage arrays are deliberately left out of reset. A reset loop over
   // a memory turns it into flops and breaks RAM inference. Only the control
   // state is reset.
   always_ff @(posedge clk) begin
      if (!rst && ram_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_wenable[k]) begin
               // NOTE: state uses non-blocking assignments so every flop samples
               // pre-edge values. Blocking here would create simulation races.
               ram[ram_index][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Cycle counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
      end else if (cycle_wr) begin
         // A loaded value replaces this edge's increment.
         cycle_count <= mem_wdata;
      end else begin
         cycle_count <= cycle_count + 32'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         fifo_mem[tail] <= mem_wdata[7:0];
      end
   end

   // The pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) tail <= tail + PW'(1);
         if (pop)     head <= head + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         // A dropped push outranks a clear on the same edge.
         overflow <= 1'b1;
      end else if (ovf_clear) begin
         overflow <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   logic [31:0] count_ext;
   logic [31:0] status_word;

   // With FIFO_DEPTH = 256, count[7:0] wraps to 0 and full marks the case.
   assign count_ext   = 32'(count);
   assign status_word = {16'b0, count_ext[7:0], 5'b0, overflow, full, empty};

   always_comb begin
      // NOTE: the default is assigned first so that every path drives
      // mem_rdata. Missing a branch would otherwise infer a latch.
      mem_rdata = '0;
      if (sel_ram) begin
         mem_rdata = ram[ram_index];
      end else begin
         case (mmio_reg)
            REG_CYCLE:     mem_rdata = cycle_count;
            REG_TX_STATUS: mem_rdata = status_word;
            default:       mem_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mcc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mcc_mem_responder
//   Directed self-checking bench for mcc_mem_responder with default parameters
//   (RAM_WORDS = 1024, FIFO_DEPTH = 8).
//
//   Inputs change and outputs are sampled just after the falling edge. That
//   keeps all activity clear of the active rising edge.
// -----------------------------------------------------------------------------
module tb_mcc_mem_responder;

   localparam logic [31:0] CYCLE_A  = 32'h8000_0000;
   localparam logic [31:0] TXDATA_A = 32'h8000_0004;
   localparam logic [31:0] STATUS_A = 32'h8000_0008;
   localparam logic [31:0] RSVD_A   = 32'h8000_000C;

   logic        clk;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wenable;
   logic [31:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int errors;
   int checks;

   mcc_mem_responder #(
      .RAM_WORDS  (1024),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wenable (mem_wenable),
      .mem_rdata   (mem_rdata),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one write for a single rising edge. The task returns at the next
   // falling edge with the write enable removed.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      mem_addr    = a;
      mem_wdata   = d;
      mem_wenable = we;
      @(negedge clk);
      mem_wenable = 4'b0000;
   endtask

   task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mem_addr    = a;
      mem_wenable = 4'b0000;
      #1;
      check(tag, mem_rdata, exp);
   endtask

   logic [7:0] drain_exp [8];

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      mem_wenable = 4'b0000;
      tx_ready    = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Reset state.
      #1;
      check("reset_tx_valid", 32'(tx_valid), 32'h0);
      check_rd("reset_status", STATUS_A, 32'h0000_0001);

      // 1. RAM byte lanes, same-cycle old data, and aliasing.
      wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
      mem_addr    = 32'h10;
      mem_wdata   = 32'h0000_00AA;
      mem_wenable = 4'b0001;
      #1;
      check("ram_same_cycle_old", mem_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      mem_wenable = 4'b0000;
      check_rd("ram_lane0", 32'h10, 32'hDEAD_BEAA);
      check_rd("ram_alias", 32'h10 + 32'd4096, 32'hDEAD_BEAA);
      check_rd("ram_low_bits_ignored", 32'h13, 32'hDEAD_BEAA);

      // 2. Cycle counter after reset, loading, and wrap.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_rd("cycle_after_5", CYCLE_A, 32'd5);
      wr(CYCLE_A, 32'hFFFF_FFFE, 4'b1111);
      check_rd("cycle_load", CYCLE_A, 32'hFFFF_FFFE);
      @(negedge clk);
      check_rd("cycle_max", CYCLE_A, 32'hFFFF_FFFF);
      @(negedge clk);
      check_rd("cycle_wrap", CYCLE_A, 32'h0000_0000);

      // Reserved and write-only registers read as zero.
      wr(RSVD_A, 32'h1234_5678, 4'b1111);
      check_rd("reserved_reads_0", RSVD_A, 32'h0);

      // 3. Fill the FIFO, overflow, and clear the overflow flag.
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(TXDATA_A, 32'(8'h41 + i), 4'b0001);
      check_rd("status_full", STATUS_A, 32'h0000_0802);
      check_rd("txdata_reads_0", TXDATA_A, 32'h0);
      check("full_tx_valid", 32'(tx_valid), 32'h1);
      check("full_head", 32'(tx_data), 32'h41);
      wr(TXDATA_A, 32'h49, 4'b0001);
      check_rd("status_overflow", STATUS_A, 32'h0000_0806);
      wr(STATUS_A, 32'h4, 4'b0001);
      check_rd("status_cleared", STATUS_A, 32'h0000_0802);

      // 4. A push to a full FIFO succeeds when a pop lands on the same edge.
      mem_addr    = TXDATA_A;
      mem_wdata   = 32'h50;
      mem_wenable = 4'b0001;
      tx_ready    = 1'b1;
      @(negedge clk);
      mem_wenable = 4'b0000;
      tx_ready    = 1'b0;
      check_rd("full_push_pop_status", STATUS_A, 32'h0000_0802);
      drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), 32'(tx_data), 32'(drain_exp[i]));
         tx_ready = 1'b1;
         @(negedge clk);
      end
      tx_ready = 1'b0;
      #1;
      check("drained_tx_valid", 32'(tx_valid), 32'h0);

      // 5. Ordered pops with tx_ready toggled, and no push-through.
      mem_addr    = TXDATA_A;
      mem_wdata   = 32'h61;
      mem_wenable = 4'b0001;
      #1;
      check("no_push_through", 32'(tx_valid), 32'h0);
      @(negedge clk);
      wr(TXDATA_A, 32'h62, 4'b0001);
      #1;
      check("pop1_data", 32'(tx_data), 32'h61);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      check("pop2_data", 32'(tx_data), 32'h62);
      @(negedge clk);
      #1;
      check("hold_valid", 32'(tx_valid), 32'h1);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      check("pop_done_valid", 32'(tx_valid), 32'h0);
      check_rd("pop_done_status", STATUS_A, 32'h0000_0001);

      // 6. A mid-drain reset discards the queue and ignores writes in the reset
      // cycle, while RAM keeps its contents.
      wr(32'h20, 32'h1234_5678, 4'b1111);
      for (int i = 0; i < 3; i++) wr(TXDATA_A, 32'(8'h71 + i), 4'b0001);
      tx_ready = 1'b1;
      @(negedge clk);
      #1;
      check("mid_drain_head", 32'(tx_data), 32'h72);
      rst         = 1'b1;
      mem_addr    = 32'h20;
      mem_wdata   = 32'hFFFF_FFFF;
      mem_wenable = 4'b1111;
      @(negedge clk);
      rst         = 1'b0;
      mem_wenable = 4'b0000;
      tx_ready    = 1'b0;
      check_rd("rst_cycle_zero", CYCLE_A, 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check_rd("rst_status", STATUS_A, 32'h0000_0001);
      check_rd("rst_ram_kept", 32'h20, 32'h1234_5678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
